// File: rtl/lmac_rx_pkg.sv
// Shared definitions for the LMAC RX FIFO reader.
// Covers the ctrl byte bit map, the framing FSM states and the output beat record.
package lmac_rx_pkg;

   localparam int CTRL_SOP    = 0;
   localparam int CTRL_EOP    = 1;
   localparam int CTRL_NB_LSB = 4;
   localparam int CTRL_ERR    = 7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_IN_PKT = 2'd1,
      ST_DROP   = 2'd2
   } rx_state_e;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        sop;
      logic        eop;
      logic        err;
   } beat_t;

   // Valid bytes are MSB-aligned: nb encodes (valid bytes - 1).
   function automatic logic [7:0] keep_from_nb(input logic [2:0] nb);
      return 8'hFF << (3'd7 - nb);
   endfunction

endpackage

// File: rtl/lmac_rx_beat_buf.sv
// Circular beat buffer whose head is visible in the same cycle; a push is accepted when not full or on a same-cycle pop.
// Outputs read as zero while empty, so the stream presents clean qualifiers whenever valid is low.
module lmac_rx_beat_buf
   import lmac_rx_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int OW    = AW + 1
) (
   input  logic          clk,
   input  logic          reset_,
   input  logic          push_i,
   input  beat_t         push_beat_i,
   input  logic          pop_i,
   output logic          head_vld_o,
   output beat_t         head_beat_o,
   output logic [OW-1:0] occ_o
);

   beat_t         mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [OW-1:0] occ_q;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop_i && (occ_q != '0);
   assign do_push = push_i && ((occ_q != OW'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_beat_i;
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         occ_q <= occ_q + OW'(do_push) - OW'(do_pop);
      end
   end

   assign head_vld_o  = (occ_q != '0);
   assign head_beat_o = head_vld_o ? mem_q[rd_ptr_q] : '0;
   assign occ_o       = occ_q;

endmodule

// File: rtl/lmac_rx_reader.sv
// Drains the LMAC RX FIFO into a framed valid/ready beat stream, 2-cycle read-to-valid, credit-gated reads never overflow.
// Define LMAC_RX_RD_STATS_EN to build the saturating frame/error/drop counters; otherwise stat_* read as zero.
module lmac_rx_reader
   import lmac_rx_pkg::*;
#(
   parameter int MAX_WORDS = 190,
   parameter int BUF_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_,
   input  logic [63:0] rx_mac_data,
   input  logic [7:0]  rx_mac_ctrl,
   input  logic        rx_mac_empty,
   output logic        rx_mac_rd,
   output logic [63:0] m_data,
   output logic [7:0]  m_keep,
   output logic        m_sop,
   output logic        m_eop,
   output logic        m_err,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] stat_frames,
   output logic [31:0] stat_errs,
   output logic [31:0] stat_drops
);

   localparam int CW = $clog2(MAX_WORDS + 1);
   localparam int OW = $clog2(BUF_DEPTH) + 1;

   rx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_q;
   logic          rd_q;
   logic          hold_vld_q, hold_vld_d;
   logic [63:0]   hold_data_q;
   logic [7:0]    hold_ctrl_q;

   logic          cur_vld;
   logic [63:0]   cur_data;
   logic [7:0]    cur_ctrl;
   logic          cur_sop;
   logic          cur_eop;
   logic [7:0]    cur_keep;
   logic          push;
   beat_t         push_beat;
   logic          term_stall;
   logic          drop_inc;
   beat_t         head;
   logic [OW-1:0] occ;
   logic [OW:0]   credit_used;
   logic          unused_sig;

   // A start word interrupting a frame is parked here while the terminator takes its push slot.
   assign cur_vld  = rd_q || hold_vld_q;
   assign cur_data = hold_vld_q ? hold_data_q : rx_mac_data;
   assign cur_ctrl = hold_vld_q ? hold_ctrl_q : rx_mac_ctrl;
   assign cur_sop  = cur_ctrl[CTRL_SOP];
   assign cur_eop  = cur_ctrl[CTRL_EOP];
   assign cur_keep = keep_from_nb(cur_ctrl[CTRL_NB_LSB +: 3]);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hold_vld_d = 1'b0;
      push       = 1'b0;
      push_beat  = '0;
      term_stall = 1'b0;
      drop_inc   = 1'b0;
      if (cur_vld) begin
         if (cur_sop && (state_q == ST_IN_PKT)) begin
            push          = 1'b1;
            push_beat.eop = 1'b1;
            push_beat.err = 1'b1;
            hold_vld_d    = 1'b1;
            term_stall    = 1'b1;
            state_d       = ST_IDLE;
         end else if (cur_sop) begin
            push           = 1'b1;
            push_beat.data = cur_data;
            push_beat.sop  = 1'b1;
            cnt_d          = CW'(1);
            if (cur_eop) begin
               push_beat.keep = cur_keep;
               push_beat.eop  = 1'b1;
               push_beat.err  = cur_ctrl[CTRL_ERR];
               state_d        = ST_IDLE;
            end else begin
               push_beat.keep = 8'hFF;
               state_d        = ST_IN_PKT;
            end
         end else begin
            case (state_q)
               ST_IN_PKT: begin
                  push           = 1'b1;
                  push_beat.data = cur_data;
                  push_beat.keep = 8'hFF;
                  cnt_d          = cnt_q + 1'b1;
                  if (cur_eop) begin
                     push_beat.keep = cur_keep;
                     push_beat.eop  = 1'b1;
                     push_beat.err  = cur_ctrl[CTRL_ERR];
                     state_d        = ST_IDLE;
                  end else if (cnt_q == CW'(MAX_WORDS - 1)) begin
                     push_beat.eop = 1'b1;
                     push_beat.err = 1'b1;
                     state_d       = ST_DROP;
                  end
               end
               ST_DROP: begin
                  if (cur_eop) begin
                     drop_inc = 1'b1;
                     state_d  = ST_IDLE;
                  end
               end
               default: drop_inc = 1'b1;
            endcase
         end
      end
   end

   // The word arriving plus any parked word count as in flight; one slot stays free for a terminator.
   assign credit_used = (OW+1)'(occ) + (OW+1)'(rd_q) + (OW+1)'(hold_vld_q);
   assign rx_mac_rd   = run_q && !rx_mac_empty && !term_stall &&
                        (credit_used < (OW+1)'(BUF_DEPTH - 1));

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         run_q       <= 1'b0;
         rd_q        <= 1'b0;
         hold_vld_q  <= 1'b0;
         hold_data_q <= '0;
         hold_ctrl_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         run_q      <= 1'b1;
         rd_q       <= rx_mac_rd;
         hold_vld_q <= hold_vld_d;
         if (term_stall) begin
            hold_data_q <= rx_mac_data;
            hold_ctrl_q <= rx_mac_ctrl;
         end
      end
   end

   lmac_rx_beat_buf #(.DEPTH(BUF_DEPTH)) u_buf (
      .clk         (clk),
      .reset_      (reset_),
      .push_i      (push),
      .push_beat_i (push_beat),
      .pop_i       (m_ready),
      .head_vld_o  (m_valid),
      .head_beat_o (head),
      .occ_o       (occ)
   );

   assign m_data = head.data;
   assign m_keep = head.keep;
   assign m_sop  = head.sop;
   assign m_eop  = head.eop;
   assign m_err  = head.err;

`ifdef LMAC_RX_RD_STATS_EN
   logic [31:0] frames_q, errs_q, drops_q;
   logic        acc_eop;

   assign acc_eop = m_valid && m_ready && m_eop;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         frames_q <= '0;
         errs_q   <= '0;
         drops_q  <= '0;
      end else begin
         if (acc_eop && (frames_q != '1)) frames_q <= frames_q + 1'b1;
         if (acc_eop && m_err && (errs_q != '1)) errs_q <= errs_q + 1'b1;
         if (drop_inc && (drops_q != '1)) drops_q <= drops_q + 1'b1;
      end
   end

   assign stat_frames = frames_q;
   assign stat_errs   = errs_q;
   assign stat_drops  = drops_q;
   assign unused_sig  = ^cur_ctrl[3:2];
`else
   assign stat_frames = '0;
   assign stat_errs   = '0;
   assign stat_drops  = '0;
   assign unused_sig  = ^{cur_ctrl[3:2], drop_inc};
`endif

endmodule

// File: tb/tb_lmac_rx_reader.sv
// Bench for lmac_rx_reader: FIFO model feeds directed frames, expected beats are queued at issue and a monitor checks them.
`timescale 1ns/1ps
module tb_lmac_rx_reader;
   import lmac_rx_pkg::*;

   localparam int MAXW = 190;

   typedef struct packed {
      logic [7:0]  ctrl;
      logic [63:0] data;
   } fw_t;

   logic        clk = 1'b0;
   logic        reset_;
   logic [63:0] rx_mac_data;
   logic [7:0]  rx_mac_ctrl;
   logic        rx_mac_empty;
   logic        rx_mac_rd;
   logic [63:0] m_data;
   logic [7:0]  m_keep;
   logic        m_sop, m_eop, m_err, m_valid;
   logic        m_ready;
   logic [31:0] stat_frames, stat_errs, stat_drops;

   fw_t   fifo_q[$];
   beat_t exp_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   int    exp_frames, exp_errs, exp_drops;
   logic [7:0] keep_tab [8];

   lmac_rx_reader #(.MAX_WORDS(MAXW), .BUF_DEPTH(4)) dut (
      .clk(clk), .reset_(reset_),
      .rx_mac_data(rx_mac_data), .rx_mac_ctrl(rx_mac_ctrl),
      .rx_mac_empty(rx_mac_empty), .rx_mac_rd(rx_mac_rd),
      .m_data(m_data), .m_keep(m_keep), .m_sop(m_sop), .m_eop(m_eop),
      .m_err(m_err), .m_valid(m_valid), .m_ready(m_ready),
      .stat_frames(stat_frames), .stat_errs(stat_errs), .stat_drops(stat_drops)
   );

   always #5 clk = ~clk;

   // MAC FIFO model: a read strobe in one cycle presents the word in the next.
   initial begin
      logic rd_s;
      fw_t  w;
      rx_mac_data  = '0;
      rx_mac_ctrl  = '0;
      rx_mac_empty = 1'b1;
      forever begin
         @(negedge clk);
         rd_s = rx_mac_rd;
         @(posedge clk);
         #1;
         if (rd_s && (fifo_q.size() != 0)) begin
            w = fifo_q.pop_front();
            rx_mac_data = w.data;
            rx_mac_ctrl = w.ctrl;
         end else begin
            rx_mac_data = 64'hDEAD_BEEF_0BAD_F00D;
            rx_mac_ctrl = 8'h03;
         end
         rx_mac_empty = (fifo_q.size() == 0);
      end
   end

   // Monitor: compares every accepted beat and checks outputs hold while stalled.
   initial begin
      beat_t act, e, held;
      logic  stall_prev;
      stall_prev = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         act = {m_data, m_keep, m_sop, m_eop, m_err};
         if (!reset_) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               n_cmp++;
               if ({m_valid, act} !== {1'b1, held}) begin
                  n_bad++;
                  $display("FAIL hold_stable: got valid=%0b beat=%h, need valid=1 beat=%h", m_valid, act, held);
               end
            end
            if (m_valid && m_ready) begin
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL unexpected_beat: got beat=%h, need no beat", act);
               end else begin
                  e = exp_q.pop_front();
                  if (act !== e) begin
                     n_bad++;
                     $display("FAIL beat: got data=%h keep=%h sop/eop/err=%b%b%b, need data=%h keep=%h sop/eop/err=%b%b%b",
                              act.data, act.keep, act.sop, act.eop, act.err, e.data, e.keep, e.sop, e.eop, e.err);
                  end
               end
            end
            stall_prev = m_valid && !m_ready;
            held = act;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d beats still expected", exp_q.size());
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, need %0h", name, act, exp);
      end
   endtask

   task automatic check_stats(input string tag);
`ifdef LMAC_RX_RD_STATS_EN
      check({tag, "_frames"}, 64'(stat_frames), 64'(exp_frames));
      check({tag, "_errs"},   64'(stat_errs),   64'(exp_errs));
      check({tag, "_drops"},  64'(stat_drops),  64'(exp_drops));
`else
      check({tag, "_frames"}, 64'(stat_frames), 64'd0);
      check({tag, "_errs"},   64'(stat_errs),   64'd0);
      check({tag, "_drops"},  64'(stat_drops),  64'd0);
`endif
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd"},    64'(rx_mac_rd), 64'd0);
      check({tag, "_valid"}, 64'(m_valid),   64'd0);
      check({tag, "_qual"},  64'({m_sop, m_eop, m_err}), 64'd0);
      check({tag, "_data"},  m_data,         64'd0);
      check({tag, "_keep"},  64'(m_keep),    64'd0);
      check_stats(tag);
   endtask

   task automatic send_word(input logic [63:0] d, input logic [7:0] c);
      fw_t w;
      w.data = d;
      w.ctrl = c;
      fifo_q.push_back(w);
   endtask

   task automatic send_frame(input int fid, input int n, input int nb, input bit e, input bit has_end);
      fw_t   w;
      beat_t b;
      bit    last;
      for (int i = 0; i < n; i++) begin
         last = has_end && (i == n - 1);
         w.data = {16'hA000 + 16'(fid), 32'h0, 16'(i)};
         w.ctrl = 8'h00;
         w.ctrl[0] = (i == 0);
         w.ctrl[1] = last;
         w.ctrl[3:2] = (i % 2 == 1) ? 2'b11 : 2'b00;
         if (last) begin
            w.ctrl[6:4] = 3'(nb);
            w.ctrl[7]   = e;
         end
         fifo_q.push_back(w);
         if (i < MAXW) begin
            b.data = w.data;
            b.keep = last ? keep_tab[nb] : 8'hFF;
            b.sop  = (i == 0);
            b.eop  = last || (i == MAXW - 1);
            b.err  = last ? e : (i == MAXW - 1);
            exp_q.push_back(b);
            if (b.eop) begin
               exp_frames++;
               if (b.err) exp_errs++;
            end
         end
      end
      if (has_end && (n > MAXW)) exp_drops++;
   endtask

   task automatic drain(input string tag);
      int t;
      t = 0;
      while (((exp_q.size() != 0) || (fifo_q.size() != 0)) && (t < 2000)) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (t >= 2000) begin
         n_bad++;
         $display("FAIL %s_drain: got %0d beats outstanding after %0d cycles, need 0", tag, exp_q.size(), t);
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      beat_t term;
      reset_  = 1'b0;
      m_ready = 1'b1;
      keep_tab = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
      exp_frames = 0;
      exp_errs   = 0;
      exp_drops  = 0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1 reset_ = 1'b1;

      // 64-byte frame, then a 61-byte frame.
      send_frame(1, 8, 7, 1'b0, 1'b1);
      drain("t1");
      check_stats("t1");
      send_frame(2, 8, 4, 1'b0, 1'b1);
      drain("t2");
      check_stats("t2");

      // Consumer stall mid-frame: reads must stop and outputs hold.
      send_frame(3, 40, 7, 1'b0, 1'b1);
      repeat (8) @(posedge clk);
      #1 m_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k >= 3) check($sformatf("t3_rd_stalled_%0d", k), 64'(rx_mac_rd), 64'd0);
      end
      @(posedge clk);
      #1 m_ready = 1'b1;
      drain("t3");
      check_stats("t3");

      // Oversize frame truncated at MAXW beats, then a normal frame.
      send_frame(4, 200, 7, 1'b0, 1'b1);
      send_frame(5, 3, 5, 1'b0, 1'b1);
      drain("t4");
      check_stats("t4");

      // Start word mid-frame: terminator beat, then the new frame.
      send_frame(6, 5, 7, 1'b0, 1'b0);
      term = '0;
      term.eop = 1'b1;
      term.err = 1'b1;
      exp_q.push_back(term);
      exp_frames++;
      exp_errs++;
      send_frame(7, 4, 3, 1'b0, 1'b1);
      drain("t5");
      check_stats("t5");

      // Single-beat errored frame, then a stray continuation word in IDLE.
      send_frame(8, 1, 2, 1'b1, 1'b1);
      send_word(64'h5555_0000_0000_0001, 8'h02);
      exp_drops++;
      drain("t6");
      check_stats("t6");

      // Reset in the middle of a frame.
      send_frame(9, 5, 0, 1'b0, 1'b0);
      drain("t7_part");
      @(posedge clk);
      #1 reset_ = 1'b0;
      exp_frames = 0;
      exp_errs   = 0;
      exp_drops  = 0;
      repeat (2) @(negedge clk);
      check_reset_outputs("t7_rst");
      @(posedge clk);
      #1 reset_ = 1'b1;
      send_word(64'h7777_0000_0000_0005, 8'h00);
      send_word(64'h7777_0000_0000_0006, 8'h00);
      send_word(64'h7777_0000_0000_0007, 8'h32);
      exp_drops += 3;
      send_frame(10, 8, 7, 1'b0, 1'b1);
      drain("t7");
      check_stats("t7");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
